cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multicycle control unit for the CPU datapath (PC, IR, register file, ALU, unified memory port).
- Sequences each instruction through fetch, decode, execute, memory and writeback by driving datapath control strobes.
- Stalls on a memory ready handshake.
- Keeps the architectural cycle and retired-instruction counters that the CPU bench reads for CPI.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  memory write (store)
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  latch instruction into IR
pc_write  out  1  unconditional PC load
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
halted  out  1  sticky, set by HALT
illegal  out  1  sticky, set by an unsupported opcode/funct
cycle_cnt  out  CNT_W  cycles since reset while not halted
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async):
  - State goes to FETCH.
  - Counters, halted and illegal clear to 0.
  - All strobes are Moore outputs decoded from state, so they are 0 during reset.
  - Reset mid-instruction abandons it; no partial retire.
- Supported opcodes:
  - R-type 0x00: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, halt 0x3F
- States and transitions:
  - FETCH:
    - Outputs: mem_req=1, iord=0, ir_write=mem_ready, pc_write=mem_ready, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=add.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Next state:
    - R-type or addi -> EXEC
    - lw/sw -> ADDR
    - beq -> BRANCH
    - j -> JUMP
    - 0x3F -> HALT
    - Anything else -> FETCH, with illegal set and no retire.
  - EXEC: alu_src_a=1; alu_src_b=0 for R-type or 2 for addi; alu_op from funct (addi uses add). Next: WB_ALU.
  - WB_ALU: reg_write=1, reg_dst=1 for R-type or 0 for addi, mem_to_reg=0. Retires; next FETCH.
  - ADDR: alu_src_a=1, alu_src_b=2, add. Next: MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_req=1, iord=1. Waits for mem_ready, then goes to WB_MEM.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Retires; next FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready, then retires and goes to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_write=alu_zero. Retires; next FETCH.
  - JUMP: pc_src=2, pc_write=1. Retires; next FETCH.
  - HALT: halted=1, all strobes 0. Retires once on entry. Absorbing; only reset exits.
- Mem handshake: mem_req is held high with address/we stable until a cycle with mem_ready=1. The transfer completes at that rising edge. mem_ready while mem_req=0 is ignored.
- Latency with mem_ready tied high:
  - R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle adds 1.
- cycle_cnt: +1 every rising edge while rst=1 and halted=0. Wraps modulo 2^CNT_W.
- instret_cnt: +1 on the edge leaving a retiring state. Wraps modulo 2^CNT_W.
- illegal is sticky; the illegal instruction does not increment instret_cnt.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode and funct constants.
  - State encoding enum.
  - alu_op, pc_src and alu_src_b encodings, reused by the ALU and datapath muxes.
- One natural sub-module: cpu_perf_cnt (cycle/instret counters with halted gating).

Test Plan:
- mem_ready=1, program add,lw,sw,beq(taken),j,halt -> cycles 4+5+4+3+3+2 = 21; instret_cnt=6; halted=1; cycle_cnt frozen at 21.
- FETCH with mem_ready low for 3 cycles -> mem_req/iord=0 held 4 cycles; ir_write/pc_write pulse only in the 4th; add completes in 7 cycles.
- beq with alu_zero=0 -> pc_write=0 in BRANCH; next fetch uses PC+4. With alu_zero=1 -> pc_write=1, pc_src=1.
- opcode 0x3E -> DECODE then FETCH; illegal=1; instret_cnt unchanged; next instruction executes normally.
- rst asserted low during MEM_RD wait -> all outputs 0 immediately; after release, state is FETCH and counters are 0.
- cycle_cnt preloaded near 2^CNT_W-1 (force) -> wraps to 0 with no side effects on instret_cnt.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, functs, FSM states and
// the datapath mux/ALU selects driven by the control unit.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    SRCB_RT = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_op_t funct_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_perf_cnt.sv
// Architectural cycle and retired-instruction counters; cycle counting
// freezes once the core has halted.
module cpu_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halted,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)  instret_cnt <= instret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and keeps the performance counters.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state, state_next;
  logic   illegal_reg;
  logic   illegal_set;
  logic   retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (illegal_set) illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    illegal_set = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok(funct)) state_next = S_EXEC;
            else begin
              state_next  = S_FETCH;
              illegal_set = 1'b1;
            end
          end
          OP_ADDI:      state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          // HALT retires on entry because the HALT state is never left
          OP_HALT: begin
            state_next = S_HALT;
            retire     = 1'b1;
          end
          default: begin
            state_next  = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_next = S_WB_ALU;
      S_WB_ALU: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDR:   state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
      S_WB_MEM: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, even though state sits in FETCH
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = SRCB_FOUR;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH2;
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (opcode == OP_RTYPE) ? SRCB_RT : SRCB_IMM;
          alu_op    = (opcode == OP_RTYPE) ? funct_alu(funct) : ALU_ADD;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE);
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PC_BRANCH;
          pc_write  = alu_zero;
        end
        S_JUMP: begin
          pc_src   = PC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state == S_HALT);
  assign illegal = illegal_reg;

  cpu_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .halted      (halted),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: acts as memory/IR, checks each instruction against
// a transaction-level model of its latency, transfers, writes and counters.
module tb_cpu_ctrl_fsm;

  localparam int W      = 8;
  localparam int MOD    = 1 << W;
  localparam int BUDGET = 40;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
  localparam logic [5:0] ADDI = 6'h08, J = 6'h02, HLT = 6'h3F;

  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, reg_dst;
  logic mem_to_reg, halted, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [W-1:0] cycle_cnt, instret_cnt;

  int n_tests = 0, n_fail = 0;
  int exp_cycle = 0, exp_instret = 0;
  logic exp_illegal = 1'b0;

  cpu_ctrl_fsm #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == R) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    return op inside {LW, SW, BEQ, ADDI, J, HLT};
  endfunction

  // Cycles per instruction with an always-ready memory
  function automatic int base_lat(input logic [5:0] op, input logic [5:0] fn);
    if (!legal(op, fn)) return 2;
    case (op)
      LW:         return 5;
      BEQ, J:     return 3;
      HLT:        return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int alu_want(input logic [5:0] op, input logic [5:0] fn);
    if (op == BEQ) return 1;
    if (op != R) return 0;
    case (fn)
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h2A: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic expect_idle_outputs(input string tag);
    check({tag, "_strobes"}, 32'({mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
          alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted, illegal}), 32'd0);
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    check({tag, "_instret_cnt"}, 32'(instret_cnt), 32'd0);
  endtask

  // Called right at a falling edge; leaves at the falling edge that starts the next fetch
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input string tag);
    int cyc = 0, rd = 0, wr = 0, rw = 0, pcw = 0, bad = 0, wait_left = wf;
    int rw_dst = 0, rw_m2r = 0, pcw_src = 0, alu_seen = 0, alu_last = 0, srcb_last = 0;
    logic fetched = 1'b0, rdy;
    logic ok = legal(op, fn);
    logic is_mem = (op == LW || op == SW);
    int lat = base_lat(op, fn) + wf + ((ok && is_mem) ? wm : 0);
    opcode = op; funct = fn; alu_zero = z;
    for (int c = 0; c < BUDGET; c++) begin
      if (fetched && mem_req && !iord) break;
      if (mem_req) begin
        if (wait_left > 0) begin rdy = 1'b0; wait_left--; end
        else rdy = 1'b1;
      end else rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      #1;
      if (mem_req && !iord) begin
        if (ir_write !== rdy || pc_write !== rdy || pc_src !== 2'd0 || mem_we !== 1'b0) bad++;
        if (rdy) begin fetched = 1'b1; wait_left = wm; end
      end else begin
        if (ir_write !== 1'b0) bad++;
        if (mem_req && rdy) begin if (mem_we) wr++; else rd++; end
        if (pc_write) begin pcw++; pcw_src = int'(pc_src); end
        if (reg_write) begin rw++; rw_dst = int'(reg_dst); rw_m2r = int'(mem_to_reg); end
        if (alu_src_a) begin alu_seen = 1; alu_last = int'(alu_op); srcb_last = int'(alu_src_b); end
      end
      cyc++;
      @(negedge clk);
    end
    exp_cycle   = (exp_cycle + lat) % MOD;
    exp_instret = (exp_instret + (ok ? 1 : 0)) % MOD;
    exp_illegal = exp_illegal | !ok;
    check({tag, "_cycles"}, cyc, (op == HLT) ? BUDGET : lat);
    check({tag, "_fetch_strobes"}, bad, 0);
    check({tag, "_reads"}, rd, (ok && op == LW) ? 1 : 0);
    check({tag, "_writes"}, wr, (ok && op == SW) ? 1 : 0);
    check({tag, "_reg_write"}, rw, (ok && op inside {R, ADDI, LW}) ? 1 : 0);
    if (rw == 1) begin
      check({tag, "_reg_dst"}, rw_dst, (op == R) ? 1 : 0);
      check({tag, "_mem_to_reg"}, rw_m2r, (op == LW) ? 1 : 0);
    end
    check({tag, "_pc_write"}, pcw, (op == J || (op == BEQ && z)) ? 1 : 0);
    if (pcw == 1) check({tag, "_pc_src"}, pcw_src, (op == J) ? 2 : 1);
    if (ok && op inside {R, ADDI, LW, SW, BEQ}) begin
      check({tag, "_alu_op"}, alu_last, alu_want(op, fn));
      check({tag, "_alu_src_b"}, srcb_last, (op == R || op == BEQ) ? 0 : 2);
    end else check({tag, "_alu_unused"}, alu_seen, 0);
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), exp_cycle);
    check({tag, "_instret_cnt"}, 32'(instret_cnt), exp_instret);
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_illegal));
    check({tag, "_halted"}, 32'(halted), (op == HLT) ? 1 : 0);
    $display("[TB] %s op=%0h fn=%0h z=%0d wf=%0d wm=%0d cycles=%0d cycle_cnt=%0d instret=%0d",
             tag, op, fn, z, wf, wm, cyc, cycle_cnt, instret_cnt);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    expect_idle_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
    exp_cycle = 0; exp_instret = 0; exp_illegal = 1'b0;
    #1;
  endtask

  logic [5:0] ops [6] = '{R, LW, SW, BEQ, ADDI, J};
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    int found;
    logic [5:0] rop, rfn;
    @(negedge clk);
    do_reset("reset0");

    // Whole program with memory always ready
    run_instr(R,   6'h20, 1'b0, 0, 0, "p_add");
    run_instr(LW,  6'h00, 1'b0, 0, 0, "p_lw");
    run_instr(SW,  6'h00, 1'b0, 0, 0, "p_sw");
    run_instr(BEQ, 6'h00, 1'b1, 0, 0, "p_beq");
    run_instr(J,   6'h00, 1'b0, 0, 0, "p_j");
    run_instr(HLT, 6'h00, 1'b0, 0, 0, "p_halt");
    check("prog_total_cycles", 32'(cycle_cnt), 32'd21);
    check("prog_total_instret", 32'(instret_cnt), 32'd6);

    // Reset while a load is waiting on memory
    do_reset("reset1");
    opcode = LW; funct = '0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req && iord) begin found = 1; break; end
      mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("memrd_reached", found, 1);
    check("memrd_holds_req", 32'({mem_req, iord, mem_we}), 32'b110);
    do_reset("reset_mid_memrd");

    run_instr(R,   6'h20, 1'b0, 3, 0, "fetch_wait_add");
    run_instr(BEQ, 6'h00, 1'b0, 0, 0, "beq_not_taken");
    run_instr(BEQ, 6'h00, 1'b1, 1, 0, "beq_taken");
    run_instr(6'h3E, 6'h00, 1'b0, 0, 0, "illegal_op");
    run_instr(R,   6'h22, 1'b0, 0, 0, "after_illegal");
    run_instr(R,   6'h3F, 1'b0, 2, 0, "illegal_funct");
    run_instr(LW,  6'h00, 1'b0, 1, 3, "lw_waits");
    run_instr(SW,  6'h00, 1'b0, 0, 2, "sw_waits");

    // Random mix, long enough for the narrow cycle counter to wrap
    for (int i = 0; i < 70; i++) begin
      rop = ops[$urandom_range(0, 5)];
      rfn = (rop == R) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run_instr(rop, rfn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end
    run_instr(HLT, 6'h00, 1'b0, 1, 0, "final_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
